nand4_sweep_checker: RTL and testbench

// Self-checking exhaustive stimulus stage for the 4-input NAND cell (ports f,a,b,c,d).

---
 rtl/nand4_sweep_checker_if.sv | 9 +
 rtl/nand4_sweep_checker.sv | 103 ++++++++++
 tb/tb_nand4_sweep_checker.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/nand4_sweep_checker_if.sv
// nand4_sweep_checker_if: stimulus and result bundle between the sweep checker (slave) and its driver (master)
interface nand4_sweep_checker_if;
  logic start, f, a, b, c, d, busy, done, pass;
  logic [15:0] truth;
  logic [4:0] err_count;
  logic [3:0] first_fail_idx;
  modport master (output start, f, input a, b, c, d, busy, done, pass, truth, err_count, first_fail_idx);
  modport slave (input start, f, output a, b, c, d, busy, done, pass, truth, err_count, first_fail_idx);
endinterface

// File: rtl/nand4_sweep_checker.sv
// nand4_sweep_checker: clocked exhaustive NAND4 sweep and truth-table check; SWEEP_GRAY_EN selects Gray application order
module nand4_sweep_checker #(
  parameter int HOLD_CYCLES = 5,
  parameter logic [15:0] EXPECT = 16'h7FFF
) (
  input logic clk,
  input logic rst,
  nand4_sweep_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
`ifdef SWEEP_GRAY_EN
  localparam bit GRAY = 1'b1;
`else
  localparam bit GRAY = 1'b0;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d, pat_q, pat_d, ffi_q, ffi_d;
  logic [3:0] nidx, app, nxt;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0] truth_q, truth_d;
  logic [4:0] err_q, err_d;
  logic hit, miss;
  assign nidx = idx_q + 4'd1;
  assign app = GRAY ? idx_q ^ (idx_q >> 1) : idx_q;
  // after pattern 15 the index wraps to 0, which also parks a..d at 0000
  assign nxt = GRAY ? nidx ^ (nidx >> 1) : nidx;
  assign hit = state_q == RUN && cnt_q == CW'(HOLD_CYCLES - 1);
  assign miss = bus.f != EXPECT[app];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    pat_d = pat_q;
    busy_d = busy_q;
    done_d = 1'b0;
    pass_d = pass_q;
    truth_d = truth_q;
    err_d = err_q;
    ffi_d = ffi_q;
    if (state_q == IDLE && bus.start) begin
      state_d = RUN;
      cnt_d = '0;
      idx_d = '0;
      pat_d = '0;
      busy_d = 1'b1;
      pass_d = 1'b0;
      truth_d = '0;
      err_d = '0;
      ffi_d = '0;
    end
    if (state_q == RUN) begin
      cnt_d = hit ? '0 : cnt_q + CW'(1);
      if (hit) begin
        truth_d[app] = bus.f;
        err_d = err_q + {4'd0, miss};
        ffi_d = (miss && err_q == 5'd0) ? app : ffi_q;
        idx_d = nidx;
        pat_d = nxt;
        if (idx_q == 4'd15) begin
          state_d = DONE;
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = err_d == 5'd0;
        end
      end
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      pat_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      truth_q <= '0;
      err_q <= '0;
      ffi_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      pat_q <= pat_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      truth_q <= truth_d;
      err_q <= err_d;
      ffi_q <= ffi_d;
    end
  end
  assign {bus.a, bus.b, bus.c, bus.d} = pat_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.pass = pass_q;
  assign bus.truth = truth_q;
  assign bus.err_count = err_q;
  assign bus.first_fail_idx = ffi_q;
endmodule

// File: tb/tb_nand4_sweep_checker.sv
// tb_nand4_sweep_checker: scoreboard bench with randomized fault tables driving f
module tb_nand4_sweep_checker;
  localparam int H = 5;
  localparam logic [15:0] EXP = 16'h7FFF;
  typedef struct {
    logic [15:0] truth;
    int err;
    int ffi;
    bit pass;
    int done_cyc;
  } exp_t;
`ifdef SWEEP_GRAY_EN
  int order [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
`else
  int order [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] tbl = EXP;
  int cyc = 0;
  int run_start = -1;
  int checks = 0;
  int fails = 0;
  bit prev_done = 1'b0;
  exp_t q [$];
  nand4_sweep_checker_if bus5 ();
  nand4_sweep_checker_if bus1 ();
  nand4_sweep_checker #(.HOLD_CYCLES(H), .EXPECT(EXP)) dut (.clk(clk), .rst(rst), .bus(bus5));
  nand4_sweep_checker #(.HOLD_CYCLES(1), .EXPECT(EXP)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  assign bus5.f = tbl[{bus5.a, bus5.b, bus5.c, bus5.d}];
  assign bus1.f = ~(bus1.a & bus1.b & bus1.c & bus1.d);
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask
  // monitor: pattern sequencing while busy, and scoreboard pop on every done
  always @(negedge clk) begin
    if (!rst) begin
      if (run_start >= 0 && bus5.busy && (cyc - run_start) / H < 16)
        chk("pattern", {bus5.a, bus5.b, bus5.c, bus5.d}, order[(cyc - run_start) / H]);
      if (bus5.done) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done at cycle %0d: got done=1 expected done=0", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("done_pulse", prev_done, 0);
          chk("truth", bus5.truth, e.truth);
          chk("err_count", bus5.err_count, e.err);
          chk("first_fail_idx", bus5.first_fail_idx, e.ffi);
          chk("pass", bus5.pass, e.pass);
          chk("busy_at_done", bus5.busy, 0);
          chk("abcd_at_done", {bus5.a, bus5.b, bus5.c, bus5.d}, 0);
        end
        run_start = -1;
      end
    end
    prev_done = bus5.done;
  end
  task automatic issue(input logic [15:0] t);
    exp_t e;
    bit found = 1'b0;
    @(negedge clk);
    tbl = t;
    e.truth = t;
    e.err = $countones(t ^ EXP);
    e.ffi = 0;
    for (int i = 0; i < 16; i++)
      if (!found && t[order[i]] != EXP[order[i]]) begin
        e.ffi = order[i];
        found = 1'b1;
      end
    e.pass = e.err == 0;
    e.done_cyc = cyc + 1 + 16 * H;
    q.push_back(e);
    bus5.start = 1'b1;
    run_start = cyc + 1;
    @(negedge clk);
    bus5.start = 1'b0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 16 * H + 4 && q.size() != 0; i++) @(negedge clk);
    chk("sweep_timeout", q.size(), 0);
    q.delete();
    repeat (2) @(negedge clk);
  endtask
  task automatic wait_pattern7();
    for (int i = 0; i < 16 * H && run_start >= 0 && cyc < run_start + 7 * H + 2; i++) @(negedge clk);
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, bus5.busy, 0);
    chk({tag, "_done"}, bus5.done, 0);
    chk({tag, "_pass"}, bus5.pass, 0);
    chk({tag, "_truth"}, bus5.truth, 0);
    chk({tag, "_err"}, bus5.err_count, 0);
    chk({tag, "_ffi"}, bus5.first_fail_idx, 0);
    chk({tag, "_abcd"}, {bus5.a, bus5.b, bus5.c, bus5.d}, 0);
  endtask
  initial begin
    bus5.start = 1'b0;
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    issue(EXP);
    wait_done();
    repeat (6) @(negedge clk);
    chk("hold_truth", bus5.truth, EXP);
    chk("hold_pass", bus5.pass, 1);
    issue(16'hFFFF);
    wait_done();
    issue(16'h0000);
    wait_done();
    for (int n = 0; n < 4; n++) begin
      issue(16'($urandom));
      wait_done();
    end
    issue(EXP ^ (16'h1 << $urandom_range(0, 15)));
    wait_done();
    issue(EXP);
    wait_pattern7();
    bus5.start = 1'b1;
    @(negedge clk);
    bus5.start = 1'b0;
    for (int i = 0; i < 16 * H + 4 && !bus5.done; i++) @(negedge clk);
    chk("done_seen", bus5.done, 1);
    bus5.start = 1'b1;
    @(negedge clk);
    bus5.start = 1'b0;
    repeat (3 * H) @(negedge clk);
    chk("restart_ignored", bus5.busy, 0);
    chk("results_kept", bus5.truth, EXP);
    q.delete();
    issue(EXP);
    wait_pattern7();
    rst = 1'b1;
    q.delete();
    run_start = -1;
    @(negedge clk);
    check_reset("midrst");
    bus5.start = 1'b1;
    @(negedge clk);
    chk("rst_beats_start", bus5.busy, 0);
    bus5.start = 1'b0;
    rst = 1'b0;
    issue(EXP);
    wait_done();
    @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("h1_pattern", {bus1.a, bus1.b, bus1.c, bus1.d}, order[i]);
      chk("h1_busy", bus1.busy, 1);
      if (i < 15) @(negedge clk);
    end
    @(negedge clk);
    chk("h1_done", bus1.done, 1);
    chk("h1_truth", bus1.truth, EXP);
    chk("h1_pass", bus1.pass, 1);
    @(negedge clk);
    chk("h1_done_drop", bus1.done, 0);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
